// File: rtl/piradip_cs_decode_driver_if.sv
// Command channel between the SPI master and the '138 chip-select driver.
// The master offers select/release commands; the driver accepts them on
// cmd_valid & cmd_ready at a rising clock edge.
interface piradip_cs_decode_driver_if #(
  parameter int SEL_WIDTH = 3
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [SEL_WIDTH-1:0] cmd_sel;
  logic                 cmd_en;

  modport master (
    output cmd_valid,
    output cmd_sel,
    output cmd_en,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_sel,
    input  cmd_en,
    output cmd_ready
  );
endinterface

// File: rtl/piradip_cs_decode_driver.sv
// Sequential driver for an external 3-to-8 '138 chip-select decoder.
// Keeps the address stable for SETUP_CYCLES before the enable rises, for
// HOLD_CYCLES after it falls, and enforces a deselect gap before the next
// enable. Enable pins are registered together so decoder outputs never glitch.
// Optional ACTIVE watchdog: define PIRADIP_CS_TIMEOUT_EN.
module piradip_cs_decode_driver #(
  parameter int SEL_WIDTH      = 3,
  parameter int SETUP_CYCLES   = 2,
  parameter int HOLD_CYCLES    = 2,
  parameter int GAP_CYCLES     = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  piradip_cs_decode_driver_if.slave  cmd,
  output logic [SEL_WIDTH-1:0]       dec_addr,
  output logic                       dec_g1,
  output logic                       dec_g2an,
  output logic                       cs_active,
  output logic                       busy,
  output logic                       timeout
);

  localparam int CMAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CMAX    = (CMAX_SH > GAP_CYCLES) ? CMAX_SH : GAP_CYCLES;
  localparam int CW      = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    GAP
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic                 pend_valid;
  logic [SEL_WIDTH-1:0] pend_sel;
  logic                 accept;

`ifdef PIRADIP_CS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
`else
  assign timeout = 1'b0;
`endif

  // Ready is decoded straight from the state register.
  always_comb begin
    cmd.cmd_ready = (state == IDLE) || (state == ACTIVE);
    accept        = cmd.cmd_valid && cmd.cmd_ready;
  end

  // Sequencer: address/enable timing, pending reselect and optional watchdog.
  // GAP counts down to zero inclusive, so it lasts GAP_CYCLES+1 cycles; with
  // GAP_CYCLES=0 the state is skipped and the exit happens at the end of HOLD.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_sel   <= '0;
      dec_addr   <= '0;
      dec_g1     <= 1'b0;
      dec_g2an   <= 1'b1;
      cs_active  <= 1'b0;
      busy       <= 1'b0;
`ifdef PIRADIP_CS_TIMEOUT_EN
      tcnt       <= '0;
      timeout    <= 1'b0;
`endif
    end else begin
`ifdef PIRADIP_CS_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept && cmd.cmd_en) begin
            dec_addr <= cmd.cmd_sel;
            cnt      <= CW'(SETUP_CYCLES);
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (cnt == CW'(1)) begin
            dec_g1    <= 1'b1;
            dec_g2an  <= 1'b0;
            cs_active <= 1'b1;
            busy      <= 1'b0;
            state     <= ACTIVE;
`ifdef PIRADIP_CS_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        ACTIVE: begin
          if (accept) begin
`ifdef PIRADIP_CS_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (!cmd.cmd_en || (cmd.cmd_sel != dec_addr)) begin
              dec_g1     <= 1'b0;
              dec_g2an   <= 1'b1;
              cs_active  <= 1'b0;
              pend_valid <= cmd.cmd_en;
              pend_sel   <= cmd.cmd_sel;
              cnt        <= CW'(HOLD_CYCLES);
              busy       <= 1'b1;
              state      <= HOLD;
            end
          end
`ifdef PIRADIP_CS_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            dec_g1     <= 1'b0;
            dec_g2an   <= 1'b1;
            cs_active  <= 1'b0;
            pend_valid <= 1'b0;
            cnt        <= CW'(HOLD_CYCLES);
            busy       <= 1'b1;
            timeout    <= 1'b1;
            state      <= HOLD;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
`endif
        end

        HOLD: begin
          if (cnt == CW'(1)) begin
            if (GAP_CYCLES == 0) begin
              if (pend_valid) begin
                dec_addr   <= pend_sel;
                pend_valid <= 1'b0;
                cnt        <= CW'(SETUP_CYCLES);
                state      <= SETUP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              cnt   <= CW'(GAP_CYCLES);
              state <= GAP;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        GAP: begin
          if (cnt == '0) begin
            if (pend_valid) begin
              dec_addr   <= pend_sel;
              pend_valid <= 1'b0;
              cnt        <= CW'(SETUP_CYCLES);
              state      <= SETUP;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piradip_cs_decode_driver.sv
// Directed bench for piradip_cs_decode_driver with default timing
// (SETUP=2, HOLD=2, GAP=1) and TIMEOUT_CYCLES=10 for the watchdog build.
module tb_piradip_cs_decode_driver;

  logic       aclk;
  logic       aresetn;
  logic [2:0] dec_addr;
  logic       dec_g1;
  logic       dec_g2an;
  logic       cs_active;
  logic       busy;
  logic       timeout;

  int unsigned pass_cnt;
  int unsigned total_cnt;
  logic        mon_on;

  piradip_cs_decode_driver_if #(.SEL_WIDTH(3)) cmd ();

  piradip_cs_decode_driver #(
    .SEL_WIDTH      (3),
    .SETUP_CYCLES   (2),
    .HOLD_CYCLES    (2),
    .GAP_CYCLES     (1),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd       (cmd.slave),
    .dec_addr  (dec_addr),
    .dec_g1    (dec_g1),
    .dec_g2an  (dec_g2an),
    .cs_active (cs_active),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic en, input logic [2:0] sel);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_en    = en;
    cmd.cmd_sel   = sel;
    tick();
    cmd.cmd_valid = 1'b0;
  endtask

  // Enable pins and cs_active must agree on every cycle.
  always @(negedge aclk) begin
    if (mon_on) begin
      chk("g1_vs_g2an", {31'd0, dec_g1}, {31'd0, ~dec_g2an});
      chk("g1_vs_cs", {31'd0, dec_g1}, {31'd0, cs_active});
    end
  end

  initial begin
    logic stay_ok;
    pass_cnt      = 0;
    total_cnt     = 0;
    mon_on        = 1'b0;
    aresetn       = 1'b0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_en    = 1'b0;
    cmd.cmd_sel   = 3'd0;
    tick();
    tick();
    chk("rst_addr", 32'(dec_addr), 32'd0);
    chk("rst_g1", 32'(dec_g1), 32'd0);
    chk("rst_g2an", 32'(dec_g2an), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    aresetn = 1'b1;
    mon_on  = 1'b1;
    tick();
    chk("idle_ready", 32'(cmd.cmd_ready), 32'd1);

    // Select 5 from IDLE: address at N, enable at N+2.
    send(1'b1, 3'd5);
    chk("sel5_addr", 32'(dec_addr), 32'd5);
    chk("sel5_g1_n", 32'(dec_g1), 32'd0);
    chk("sel5_busy", 32'(busy), 32'd1);
    chk("sel5_ready", 32'(cmd.cmd_ready), 32'd0);
    tick();
    chk("sel5_g1_n1", 32'(dec_g1), 32'd0);
    tick();
    chk("sel5_g1_n2", 32'(dec_g1), 32'd1);
    chk("sel5_g2an_n2", 32'(dec_g2an), 32'd0);
    chk("sel5_cs_n2", 32'(cs_active), 32'd1);
    chk("sel5_busy_n2", 32'(busy), 32'd0);
    chk("sel5_ready_n2", 32'(cmd.cmd_ready), 32'd1);

    // Release: enable off at M, address held, busy through HOLD+GAP.
    send(1'b0, 3'd0);
    chk("rel_g1_m", 32'(dec_g1), 32'd0);
    chk("rel_addr_m", 32'(dec_addr), 32'd5);
    chk("rel_busy_m", 32'(busy), 32'd1);
    tick();
    chk("rel_addr_m1", 32'(dec_addr), 32'd5);
    tick();
    chk("rel_addr_m2", 32'(dec_addr), 32'd5);
    chk("rel_busy_m2", 32'(busy), 32'd1);
    tick();
    chk("rel_busy_m3", 32'(busy), 32'd1);
    chk("rel_ready_m3", 32'(cmd.cmd_ready), 32'd0);
    tick();
    chk("rel_busy_m4", 32'(busy), 32'd0);
    chk("rel_ready_m4", 32'(cmd.cmd_ready), 32'd1);
    chk("rel_g1_m4", 32'(dec_g1), 32'd0);

    // Reselect 5 -> 2: next enable at M+H+G+S+1 = M+6.
    send(1'b1, 3'd5);
    tick();
    tick();
    chk("rs_g1_on5", 32'(dec_g1), 32'd1);
    send(1'b1, 3'd2);
    chk("rs_g1_m", 32'(dec_g1), 32'd0);
    chk("rs_addr_m", 32'(dec_addr), 32'd5);
    tick();
    chk("rs_addr_m1", 32'(dec_addr), 32'd5);
    tick();
    chk("rs_addr_m2", 32'(dec_addr), 32'd5);
    tick();
    chk("rs_addr_m3", 32'(dec_addr), 32'd5);
    chk("rs_g1_m3", 32'(dec_g1), 32'd0);
    tick();
    chk("rs_addr_m4", 32'(dec_addr), 32'd2);
    chk("rs_g1_m4", 32'(dec_g1), 32'd0);
    chk("rs_busy_m4", 32'(busy), 32'd1);
    tick();
    chk("rs_g1_m5", 32'(dec_g1), 32'd0);
    tick();
    chk("rs_g1_m6", 32'(dec_g1), 32'd1);
    chk("rs_addr_m6", 32'(dec_addr), 32'd2);

    // Same-select while ACTIVE is a one-cycle no-op.
    send(1'b1, 3'd2);
    chk("nop_act_g1", 32'(dec_g1), 32'd1);
    chk("nop_act_addr", 32'(dec_addr), 32'd2);
    chk("nop_act_busy", 32'(busy), 32'd0);
    chk("nop_act_ready", 32'(cmd.cmd_ready), 32'd1);

    // Release back to IDLE, then a release in IDLE is a no-op.
    send(1'b0, 3'd0);
    repeat (4) tick();
    chk("back_idle_ready", 32'(cmd.cmd_ready), 32'd1);
    send(1'b0, 3'd4);
    chk("nop_idle_ready", 32'(cmd.cmd_ready), 32'd1);
    chk("nop_idle_busy", 32'(busy), 32'd0);
    chk("nop_idle_g1", 32'(dec_g1), 32'd0);
    chk("nop_idle_addr", 32'(dec_addr), 32'd2);

    // Asynchronous reset during SETUP.
    send(1'b1, 3'd6);
    chk("rsu_addr_pre", 32'(dec_addr), 32'd6);
    #2 aresetn = 1'b0;
    #1;
    chk("rsu_addr", 32'(dec_addr), 32'd0);
    chk("rsu_g1", 32'(dec_g1), 32'd0);
    chk("rsu_g2an", 32'(dec_g2an), 32'd1);
    chk("rsu_busy", 32'(busy), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // Asynchronous reset during ACTIVE.
    send(1'b1, 3'd7);
    tick();
    tick();
    chk("rac_g1_pre", 32'(dec_g1), 32'd1);
    #2 aresetn = 1'b0;
    #1;
    chk("rac_addr", 32'(dec_addr), 32'd0);
    chk("rac_g1", 32'(dec_g1), 32'd0);
    chk("rac_g2an", 32'(dec_g2an), 32'd1);
    chk("rac_cs", 32'(cs_active), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // Watchdog behaviour in ACTIVE with no further commands.
    send(1'b1, 3'd3);
    tick();
    tick();
    chk("wd_g1_on", 32'(dec_g1), 32'd1);
`ifdef PIRADIP_CS_TIMEOUT_EN
    stay_ok = 1'b1;
    repeat (9) begin
      tick();
      if (dec_g1 !== 1'b1 || timeout !== 1'b0) stay_ok = 1'b0;
    end
    chk("wd_before_limit", 32'(stay_ok), 32'd1);
    tick();
    chk("wd_g1_drop", 32'(dec_g1), 32'd0);
    chk("wd_pulse", 32'(timeout), 32'd1);
    chk("wd_addr_held", 32'(dec_addr), 32'd3);
    tick();
    chk("wd_pulse_end", 32'(timeout), 32'd0);
    chk("wd_addr_m1", 32'(dec_addr), 32'd3);
    chk("wd_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("wd_idle_ready", 32'(cmd.cmd_ready), 32'd1);
    chk("wd_idle_busy", 32'(busy), 32'd0);
`else
    stay_ok = 1'b1;
    repeat (120) begin
      tick();
      if (dec_g1 !== 1'b1 || timeout !== 1'b0) stay_ok = 1'b0;
    end
    chk("wd_stays_on", 32'(stay_ok), 32'd1);
    chk("wd_no_pulse", 32'(timeout), 32'd0);
`endif

    mon_on = 1'b0;
    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/piradip_cs_decode_driver.md
Name: piradip_cs_decode_driver

Overview:
- Sequential driver for an external 3-to-8 chip-select decoder of the '138 type (A/B/C address, G1 active-high enable, G2A/G2B active-low enables) used on SPI boards.
- Accepts select/deselect commands from the SPI master over a valid/ready handshake.
- Drives the decoder's address and enable pins and guarantees address setup and hold around every enable edge, plus a minimum deselect gap.
- Ensures no glitch ever reaches a decoder output.

Parameters:
- SEL_WIDTH, 3, decoder address width (legal 1..4).
- SETUP_CYCLES, 2, aclk cycles the address is stable before enable asserts (legal >= 1).
- HOLD_CYCLES, 2, aclk cycles the address is held after enable deasserts (legal >= 1).
- GAP_CYCLES, 1, minimum aclk cycles with enable deasserted before the next enable (legal >= 0).
- TIMEOUT_CYCLES, 65535, watchdog limit for the ACTIVE state (used only with the optional feature).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid & ready at an aclk rising edge.
- cmd_sel  in  SEL_WIDTH  target decoder output index.
- cmd_en  in  1  1 = select cmd_sel, 0 = release.
- dec_addr  out  SEL_WIDTH  drives decoder {C,B,A}.
- dec_g1  out  1  decoder G1 (active high).
- dec_g2an  out  1  decoder G2A/G2B (active low, both pins tied to this signal).
- cs_active  out  1  high while the decoder is enabled.
- busy  out  1  high in SETUP/HOLD/GAP.
- timeout  out  1  one-cycle pulse on watchdog release.

Behaviour:
- Clock and reset are decided: one clock, aclk; reset aresetn is asynchronous, active-low.
- All outputs are registered. cmd_ready is the exception: it is decoded from the state register only.
- Reset values: dec_addr=0, dec_g1=0, dec_g2an=1, cs_active=0, busy=0, timeout=0, state=IDLE. All counters are 0.
- Reset asserted mid-sequence disables the decoder immediately (asynchronously). No hold is honoured.
- States and transitions:
  - IDLE: cmd_ready=1.
    - Accepting en=1 loads dec_addr<=cmd_sel, sets the counter to SETUP_CYCLES and goes to SETUP.
    - Accepting en=0 is a no-op and stays in IDLE.
  - SETUP: cmd_ready=0, busy=1, enable stays off. The counter decrements each cycle. On reaching 0, dec_g1<=1, dec_g2an<=0, cs_active<=1, go to ACTIVE.
  - ACTIVE: cmd_ready=1.
    - Accept en=1 with cmd_sel==dec_addr: no-op.
    - Accept en=0: disable enable on the next edge, counter<=HOLD_CYCLES, go to HOLD.
    - Accept en=1 with a different cmd_sel: store it as pending and go to HOLD the same way.
  - HOLD: dec_addr is unchanged, busy=1. On count 0, go to GAP with counter<=GAP_CYCLES. If GAP_CYCLES=0, go straight to the GAP exit action.
  - GAP exit:
    - Pending reselect: dec_addr<=pending, counter<=SETUP_CYCLES, go to SETUP.
    - No pending reselect: go to IDLE.
- Latency, select from IDLE:
  - Command accepted at edge N.
  - dec_addr is valid after edge N.
  - Enable is asserted after edge N+SETUP_CYCLES.
- Latency, release from ACTIVE:
  - Release accepted at edge M.
  - Enable is deasserted after edge M.
  - dec_addr is frozen through edge M+HOLD_CYCLES.
  - Earliest next enable is after edge M+HOLD_CYCLES+GAP_CYCLES+SETUP_CYCLES (+1 if GAP_CYCLES>0, due to the GAP state cycle).
- Enable invariants:
  - dec_g1 and dec_g2an always change on the same edge; they are never inconsistent.
  - dec_addr never changes while cs_active=1.
  - dec_addr never changes within HOLD_CYCLES after cs_active falls.
- A cmd_valid held during SETUP/HOLD/GAP is not accepted. Its payload must be held stable by the sender (AXI-stream rule); the block does not drop it.

Optional Feature:
- Macro: PIRADIP_CS_TIMEOUT_EN.
- Defined:
  - A counter runs while in ACTIVE and clears on every accepted command.
  - When it reaches TIMEOUT_CYCLES, the block performs a release exactly as for en=0, discarding any pending reselect.
  - timeout pulses high for one cycle on the edge enable drops.
- Undefined: no counter is synthesized, timeout is tied to 0, and ACTIVE persists indefinitely.

Test Plan:
- Reset, then cmd en=1 sel=5 (defaults) → dec_addr=5 the cycle after acceptance; dec_g1=1/dec_g2an=0 exactly 2 cycles later; cs_active=1.
- From ACTIVE sel=5, cmd en=0 → enable off next cycle; dec_addr stays 5 for 2 cycles; busy for HOLD+GAP; back to IDLE with cmd_ready=1.
- From ACTIVE sel=5, cmd en=1 sel=2 → enable off, addr=5 held 2 cycles, 1 gap cycle, addr=2, enable on 2 cycles later; enable never high while addr≠ the selected value.
- cmd en=1 sel=5 while ACTIVE sel=5, and cmd en=0 in IDLE → accepted in one cycle, no output toggles.
- Assert aresetn=0 during SETUP and again during ACTIVE → dec_g1=0, dec_g2an=1, dec_addr=0 immediately, without waiting for aclk.
- With PIRADIP_CS_TIMEOUT_EN and TIMEOUT_CYCLES=10: select sel=3, send no commands → enable drops after 10 ACTIVE cycles, timeout pulses once, hold/gap honoured. Without the macro → enable stays on for 100+ cycles and timeout stays 0.
